// File: rtl/niu32_io_responder.sv
// rtl/niu32_io_responder.sv - Niu32 memory-mapped I/O target: HEX/LED registers, debounced KEY/SWITCH, key-press capture
module niu32_io_responder #(
    parameter int                    WORD_SIZE       = 32,
    parameter logic [WORD_SIZE-1:0]  ADDR_HEX        = 32'hFFFF0000,
    parameter logic [WORD_SIZE-1:0]  ADDR_LEDR       = 32'hFFFF0020,
    parameter logic [WORD_SIZE-1:0]  ADDR_LEDG       = 32'hFFFF0040,
    parameter logic [WORD_SIZE-1:0]  ADDR_KEY        = 32'hFFFF0100,
    parameter logic [WORD_SIZE-1:0]  ADDR_KEYEDGE    = 32'hFFFF0104,
    parameter logic [WORD_SIZE-1:0]  ADDR_SWITCH     = 32'hFFFF0120,
    parameter int                    DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 rsp_valid,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    input  logic [3:0]           KEY,
    input  logic [9:0]           SWITCH,
    output logic [15:0]          hex_out,
    output logic [9:0]           LEDR,
    output logic [7:0]           LEDG
);

    localparam int NIN = 14;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
    // Key synchronizers idle at 1 (released) so reset never looks like a press.
    localparam logic [NIN-1:0] SYNC_RST = {10'b0, 4'hF};

    typedef enum logic {IDLE, RESP} state_t;

    state_t           state, state_nxt;
    logic             alive;
    logic [NIN-1:0]   sync1, sync2, cond, deb, deb_nxt;
    logic [CW-1:0]    cnt     [NIN];
    logic [CW-1:0]    cnt_nxt [NIN];
    logic [3:0]       keyedge, keyedge_nxt, key_rise, edge_clr;
    logic             accept, rd_err, is_ro;
    logic [WORD_SIZE-1:0] rd_val;
    logic             unused_wdata;

    assign unused_wdata = &{1'b0, req_wdata[WORD_SIZE-1:16]};

    // Bits [3:0] are keys, [13:4] switches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
        end else begin
            sync1 <= {SWITCH, KEY};
            sync2 <= sync1;
        end
    end

    assign cond = {sync2[13:4], ~sync2[3:0]};

    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < NIN; i++) begin
            cnt_nxt[i] = '0;
            if (cond[i] != deb[i]) begin
                if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1))
                    deb_nxt[i] = cond[i];
                else
                    cnt_nxt[i] = cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb <= '0;
            for (int i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            deb <= deb_nxt;
            for (int i = 0; i < NIN; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    assign key_rise  = deb_nxt[3:0] & ~deb[3:0];
    assign req_ready = alive && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_ready && req_valid;

    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        is_ro  = 1'b0;
        case (req_addr)
            ADDR_HEX:     rd_val = {{(WORD_SIZE-16){1'b0}}, hex_out};
            ADDR_LEDR:    rd_val = {{(WORD_SIZE-10){1'b0}}, LEDR};
            ADDR_LEDG:    rd_val = {{(WORD_SIZE-8){1'b0}}, LEDG};
            ADDR_KEY:     begin rd_val = {{(WORD_SIZE-4){1'b0}}, deb[3:0]}; is_ro = 1'b1; end
            ADDR_KEYEDGE: rd_val = {{(WORD_SIZE-4){1'b0}}, keyedge};
            ADDR_SWITCH:  begin rd_val = {{(WORD_SIZE-10){1'b0}}, deb[13:4]}; is_ro = 1'b1; end
            default:      rd_err = 1'b1;
        endcase
        if (req_write && is_ro) rd_err = 1'b1;
    end

    // A press captured on the same edge as a clearing write must survive.
    always_comb begin
        edge_clr = 4'b0;
        if (accept && req_write && req_addr == ADDR_KEYEDGE) edge_clr = req_wdata[3:0];
        keyedge_nxt = (keyedge & ~edge_clr) | key_rise;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            alive     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            keyedge   <= 4'b0;
            hex_out   <= 16'b0;
            LEDR      <= 10'b0;
            LEDG      <= 8'b0;
        end else begin
            state     <= state_nxt;
            alive     <= 1'b1;
            keyedge   <= keyedge_nxt;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (accept) begin
                rsp_err <= rd_err;
                if (!req_write && !rd_err) rsp_rdata <= rd_val;
                if (req_write && !rd_err) begin
                    case (req_addr)
                        ADDR_HEX:  hex_out <= req_wdata[15:0];
                        ADDR_LEDR: LEDR    <= req_wdata[9:0];
                        ADDR_LEDG: LEDG    <= req_wdata[7:0];
                        default:   ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_niu32_io_responder.sv
// tb/tb_niu32_io_responder.sv - randomized self-checking bench for niu32_io_responder with a behavioural model
module tb_niu32_io_responder;

    localparam int D = 4;
    localparam logic [31:0] A_HEX = 32'hFFFF0000, A_LEDR = 32'hFFFF0020, A_LEDG = 32'hFFFF0040,
                            A_KEY = 32'hFFFF0100, A_KEDGE = 32'hFFFF0104, A_SW = 32'hFFFF0120;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SWITCH = '0;
    logic [15:0] hex_out;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;

    niu32_io_responder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .KEY(KEY), .SWITCH(SWITCH), .hex_out(hex_out), .LEDR(LEDR), .LEDG(LEDG)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: inputs are seen two edges late; a bit is adopted once the
    // last D seen values all disagree with the adopted one.
    logic [13:0] m_d1, m_d2, m_deb, m_nd, m_s, sq[$];
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [3:0]  m_kedge, m_clr;
    logic        m_pend, m_all;
    logic [31:0] m_paddr, m_pdata;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_d1 = 14'h000F; m_d2 = 14'h000F; sq.delete();
            m_deb = '0; m_hex = '0; m_ledr = '0; m_ledg = '0; m_kedge = '0; m_pend = 1'b0;
        end else begin
            m_s = {m_d2[13:4], ~m_d2[3:0]};
            m_d2 = m_d1;
            m_d1 = {SWITCH, KEY};
            sq.push_back(m_s);
            if (sq.size() > D) void'(sq.pop_front());
            m_nd = m_deb;
            if (sq.size() == D) begin
                for (int i = 0; i < 14; i++) begin
                    m_all = 1'b1;
                    for (int j = 0; j < D; j++) if (sq[j][i] == m_deb[i]) m_all = 1'b0;
                    if (m_all) m_nd[i] = ~m_deb[i];
                end
            end
            m_clr = 4'b0;
            if (m_pend) begin
                if (m_paddr == A_HEX)   m_hex  = m_pdata[15:0];
                if (m_paddr == A_LEDR)  m_ledr = m_pdata[9:0];
                if (m_paddr == A_LEDG)  m_ledg = m_pdata[7:0];
                if (m_paddr == A_KEDGE) m_clr  = m_pdata[3:0];
            end
            m_kedge = (m_kedge & ~m_clr) | (m_nd[3:0] & ~m_deb[3:0]);
            m_deb = m_nd;
            m_pend = 1'b0;
        end
    end

    logic [31:0] last_rdata;

    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        logic        e_err;
        logic [31:0] e_rd;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_before_accept", {31'b0, req_ready}, 32'h1);
        chk("idle_rsp", {rsp_valid, rsp_err, rsp_rdata[29:0]}, 32'h0);
        e_err = 1'b0; e_rd = '0;
        case (addr)
            A_HEX:   e_rd = {16'b0, m_hex};
            A_LEDR:  e_rd = {22'b0, m_ledr};
            A_LEDG:  e_rd = {24'b0, m_ledg};
            A_KEY:   begin e_rd = {28'b0, m_deb[3:0]}; e_err = wr; end
            A_KEDGE: e_rd = {28'b0, m_kedge};
            A_SW:    begin e_rd = {22'b0, m_deb[13:4]}; e_err = wr; end
            default: e_err = 1'b1;
        endcase
        if (wr || e_err) e_rd = '0;
        if (wr && !e_err) begin m_pend = 1'b1; m_paddr = addr; m_pdata = wdata; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("ready_in_resp", {31'b0, req_ready}, 32'h0);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("outputs", {hex_out, LEDR, LEDG[5:0]}, {m_hex, m_ledr, m_ledg[5:0]});
        chk("ledg_hi", {30'b0, LEDG[7:6]}, {30'b0, m_ledg[7:6]});
        last_rdata = rsp_rdata;
        @(negedge clk);
        chk("rsp_one_cycle", {31'b0, rsp_valid}, 32'h0);
    endtask

    logic [31:0] addrs [8] = '{A_HEX, A_LEDR, A_LEDG, A_KEY, A_KEDGE, A_SW, 32'hFFFF0010, 32'h0};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'h0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata[29:0]}, 32'h0);
        chk("rst_outs", {hex_out, LEDR, LEDG[5:0]}, 32'h0);
        reset = 1'b1;

        access(1'b1, A_HEX, 32'h0000BEEF);
        chk("hex_beef", {16'b0, hex_out}, 32'h0000BEEF);
        access(1'b0, A_HEX, 32'h0);
        chk("hex_load", last_rdata, 32'h0000BEEF);

        // KEY[2] press; back-to-back KEY loads track the debounce timing.
        @(posedge clk); #1 KEY = 4'b1011;
        for (int i = 0; i < 6; i++) access(1'b0, A_KEY, 32'h0);
        chk("key2_pressed", last_rdata, 32'h4);
        access(1'b0, A_KEDGE, 32'h0);
        chk("kedge_set", last_rdata, 32'h4);
        access(1'b1, A_KEDGE, 32'h4);
        access(1'b0, A_KEDGE, 32'h0);
        chk("kedge_clr", last_rdata, 32'h0);
        access(1'b0, A_KEY, 32'h0);
        chk("key_still", last_rdata, 32'h4);

        // KEY[0] glitch shorter than the debounce window.
        @(posedge clk); #1 KEY = 4'b1010;
        repeat (3) @(posedge clk);
        #1 KEY = 4'b1011;
        repeat (8) @(posedge clk);
        access(1'b0, A_KEY, 32'h0);
        chk("glitch_key", last_rdata, 32'h4);
        access(1'b0, A_KEDGE, 32'h0);
        chk("glitch_kedge", last_rdata, 32'h0);

        // Error responses leave outputs untouched.
        access(1'b1, A_LEDR, 32'h155);
        access(1'b1, A_SW, 32'hFFFFFFFF);
        access(1'b0, 32'hFFFF0010, 32'h0);
        access(1'b1, A_KEY, 32'hF);
        chk("err_ledr", {22'b0, LEDR}, 32'h155);

        // KEY[1] press, release, re-press that lands on a clearing store.
        @(posedge clk); #1 KEY = 4'b1001;
        repeat (10) @(posedge clk);
        #1 KEY = 4'b1011;
        repeat (10) @(posedge clk);
        #1 KEY = 4'b1001;
        repeat (4) @(posedge clk);
        access(1'b1, A_KEDGE, 32'h2);
        access(1'b0, A_KEDGE, 32'h0);
        chk("set_wins", {31'b0, last_rdata[1]}, 32'h1);

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
                KEY = 4'($urandom); SWITCH = 10'($urandom);
                repeat ($urandom_range(0, 6)) @(posedge clk);
            end
            if ($urandom_range(0, 7) == 0)
                access(1'($urandom), $urandom, $urandom);
            else
                access(1'($urandom), addrs[$urandom_range(0, 7)], $urandom);
        end

        // Reset right after a store is accepted.
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = A_LEDR; req_wdata = 32'h3FF;
        @(negedge clk);
        chk("mid_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rsp", {30'b0, rsp_valid, req_ready}, 32'h0);
            chk("mid_ledr", {22'b0, LEDR}, 32'h0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("post_ready", {31'b0, req_ready}, 32'h1);
        chk("post_rsp", {31'b0, rsp_valid}, 32'h0);
        access(1'b0, A_LEDR, 32'h0);
        chk("post_ledr", last_rdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/niu32_io_responder.md
Name: niu32_io_responder

Overview:
- Memory-mapped I/O target for the Niu32 core; responds to the core's load/store requests in the 0xFFFF0000 I/O window.
- Owns the HEX, LEDR and LEDG output registers.
- Synchronizes and debounces the board KEY and SWITCH inputs, and keeps a sticky key-press capture register.
- Uses a valid/ready request and single-cycle response handshake, so the core's memory stage sees a fixed two-cycle I/O access.

Parameters:
- WORD_SIZE, 32, data/address width
- ADDR_HEX, 32'hFFFF0000, HEX display register (R/W, low 16 bits)
- ADDR_LEDR, 32'hFFFF0020, red LED register (R/W, low 10 bits)
- ADDR_LEDG, 32'hFFFF0040, green LED register (R/W, low 8 bits)
- ADDR_KEY, 32'hFFFF0100, debounced key state (read-only)
- ADDR_KEYEDGE, 32'hFFFF0104, sticky key-press bits (read; write-1-to-clear)
- ADDR_SWITCH, 32'hFFFF0120, debounced switch state (read-only)
- DEBOUNCE_CYCLES, 16, consecutive cycles an input must differ before it is adopted (>=2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_write  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_ready  out  1  responder can accept a request
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load data, valid with rsp_valid
- rsp_err  out  1  unmapped address or write to a read-only register, valid with rsp_valid
- KEY  in  4  raw board keys, active-low, asynchronous
- SWITCH  in  10  raw board switches, asynchronous
- hex_out  out  16  four nibbles to the SevenSeg instances (HEX3..HEX0 = [15:12]..[3:0])
- LEDR  out  10  red LEDs
- LEDG  out  8  green LEDs

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (asynchronous assert, synchronous deassert):
  - hex_out, LEDR, LEDG, KEYEDGE = 0; debounced key and switch state = 0; counters = 0.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, req_ready = 0; FSM in IDLE.
- FSM, two states:
  - IDLE: req_ready = 1. On a clock edge with req_valid=1, the request is accepted and the FSM goes to RESP.
  - RESP: req_ready = 0; rsp_valid = 1 for exactly one cycle; then IDLE.
  - Throughput: one access per 2 cycles. Response latency: 1 cycle after acceptance.
- Write side effects are applied on the accept edge:
  - HEX takes wdata[15:0], LEDR takes wdata[9:0], LEDG takes wdata[7:0].
  - KEYEDGE clears the bits where wdata[3:0] is 1.
- Read data is registered on the accept edge and returned zero-extended:
  - HEX/LEDR/LEDG return the current register value.
  - KEY returns {28'b0, pressed[3:0]}, with pressed active-high.
  - KEYEDGE returns {28'b0, edge[3:0]}.
  - SWITCH returns {22'b0, sw[9:0]}.
- Decoding is an exact 32-bit address compare, no aliasing. Then:
  - Unmapped address: rsp_err = 1, rdata = 0, no side effect.
  - Store to KEY or SWITCH: rsp_err = 1, no side effect.
  - Loads never have side effects, including KEYEDGE (no clear-on-read).
  - rsp_err and rsp_rdata are 0 whenever rsp_valid = 0.
- Input conditioning: every KEY and SWITCH bit goes through a 2-flop synchronizer, then its own debounce counter.
  - Counter clears whenever the synced bit equals the debounced bit.
  - Otherwise the counter increments. On the edge where it would reach DEBOUNCE_CYCLES, the debounced bit takes the synced value and the counter clears.
  - Latency from a stable raw change to the debounced change: 2 + DEBOUNCE_CYCLES edges.
  - A pulse shorter than DEBOUNCE_CYCLES synced cycles is ignored.
  - KEY is inverted after the synchronizer, so pressed = ~KEY.
- KEYEDGE: bit i sets on the cycle debounced pressed[i] goes 0->1, and stays set until cleared by a write.
  - Set and write-1-to-clear on the same edge: set wins, bit stays 1.
- Reset asserted mid-transaction: the request is dropped and no rsp_valid is ever produced for it. Output registers return to 0 immediately, without waiting for clk.
- req_valid while in RESP is ignored (not queued). The core must hold the request until it is accepted.

Test Plan:
- Reset released, store 32'h0000BEEF to 0xFFFF0000 -> req_ready low one cycle; rsp_valid=1, rsp_err=0 next cycle; hex_out=16'hBEEF; a following load returns 32'h0000BEEF.
- DEBOUNCE_CYCLES=4, KEY[2] held low 10 cycles -> KEY load returns 32'h4 starting exactly 6 edges after the change; KEYEDGE reads 32'h4. Store 32'h4 to KEYEDGE -> KEYEDGE reads 0 while KEY still reads 32'h4.
- KEY[0] low for 3 cycles, then high -> debounced state and KEYEDGE stay 0.
- Store to 0xFFFF0120 and load from 0xFFFF0010 -> rsp_err=1 on both, rdata=0, LEDR/LEDG/hex_out unchanged.
- KEYEDGE bit 1 set, then a new KEY[1] press debounces on the same edge as a store of 32'h2 to KEYEDGE -> bit 1 remains 1.
- Store to LEDR accepted, reset asserted before the response cycle -> rsp_valid never pulses, LEDR=0, req_ready=0 until reset deasserts, then 1.
